// File: rtl/up_counter_wrap.sv
// Up-counter 0..MAX with wrap to 0 and a registered one-cycle overflow pulse.
// Ports: clk, en (count enable), rst (async, active high), count, overflow.
module up_counter_wrap #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned MAX   = 7
) (
   input  logic             clk,
   input  logic             en,
   input  logic             rst,
   output logic [WIDTH-1:0] count,
   output logic             overflow
);

   localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0] ALL1  = '1;

   logic at_max;
   logic above_max;

   assign at_max = (count == MAX_V);

   // A value above MAX can only exist when MAX is not the natural top
   // of the range; otherwise the compare is constant false.
   generate
      if (MAX_V != ALL1) begin : g_above
         assign above_max = (count > MAX_V);
      end else begin : g_no_above
         assign above_max = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (en) begin
         if (at_max) begin
            count    <= '0;
            overflow <= 1'b1;
         end else if (above_max) begin
            // Recover from an out-of-range value silently.
            count    <= '0;
            overflow <= 1'b0;
         end else begin
            count    <= count + ONE;
            overflow <= 1'b0;
         end
      end else begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_up_counter_wrap.sv
// Directed bench for up_counter_wrap across three parameter sets.
// Expected values are hand-computed from the counter behaviour.
module tb_up_counter_wrap;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       en_a, rst_a, ov_a;
   logic [2:0] cnt_a;
   logic       en_b, rst_b, ov_b;
   logic [3:0] cnt_b;
   logic       en_c, rst_c, ov_c;
   logic [1:0] cnt_c;

   int n_checks = 0;
   int n_fails  = 0;

   up_counter_wrap #(.WIDTH(3), .MAX(7)) dut_a (
      .clk(clk), .en(en_a), .rst(rst_a), .count(cnt_a), .overflow(ov_a));
   up_counter_wrap #(.WIDTH(4), .MAX(9)) dut_b (
      .clk(clk), .en(en_b), .rst(rst_b), .count(cnt_b), .overflow(ov_b));
   up_counter_wrap #(.WIDTH(2), .MAX(0)) dut_c (
      .clk(clk), .en(en_c), .rst(rst_c), .count(cnt_c), .overflow(ov_c));

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one rising edge, then settle 1 time unit past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int ov_cnt;
   int first_ov;
   int last_ov;

   initial begin
      en_a = 0; en_b = 0; en_c = 0;
      rst_a = 1; rst_b = 1; rst_c = 1;
      #2;
      check("a_reset_cnt", 32'(cnt_a), 0);
      check("a_reset_ov", 32'(ov_a), 0);
      tick();
      check("b_reset_cnt", 32'(cnt_b), 0);
      check("c_reset_cnt", 32'(cnt_c), 0);
      rst_a = 0;

      // en high for 8 edges: 1..7 then wrap
      en_a = 1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("a_run_cnt%0d", k), 32'(cnt_a), (k == 8) ? 0 : k);
         check($sformatf("a_run_ov%0d", k), 32'(ov_a), (k == 8) ? 1 : 0);
      end
      en_a = 0;
      tick();
      check("a_hold_cnt", 32'(cnt_a), 0);
      check("a_ov_drop", 32'(ov_a), 0);

      // toggled enable: 1,0,1,0
      en_a = 1; tick();
      check("a_tog1_cnt", 32'(cnt_a), 1);
      en_a = 0; tick();
      check("a_tog2_cnt", 32'(cnt_a), 1);
      en_a = 1; tick();
      check("a_tog3_cnt", 32'(cnt_a), 2);
      en_a = 0; tick();
      check("a_tog4_cnt", 32'(cnt_a), 2);
      check("a_tog_ov", 32'(ov_a), 0);

      // async reset mid-count at 5
      en_a = 1;
      tick(); tick(); tick();
      check("a_at5", 32'(cnt_a), 5);
      en_a = 0;
      #1 rst_a = 1;
      #1;
      check("a_async_cnt", 32'(cnt_a), 0);
      check("a_async_ov", 32'(ov_a), 0);
      tick();
      check("a_rst_held", 32'(cnt_a), 0);
      rst_a = 0;
      en_a = 1;
      tick();
      check("a_first_after_rst", 32'(cnt_a), 1);

      // run to 7, then rst and en together at the wrap edge
      for (int k = 0; k < 6; k++) tick();
      check("a_at7", 32'(cnt_a), 7);
      rst_a = 1;
      tick();
      check("a_rstwrap_cnt", 32'(cnt_a), 0);
      check("a_rstwrap_ov", 32'(ov_a), 0);
      rst_a = 0; en_a = 0;
      tick();
      check("a_rstwrap_ov2", 32'(ov_a), 0);

      // WIDTH=4 MAX=9: 20 enabled edges, two wraps 10 apart
      rst_b = 0; en_b = 1;
      ov_cnt = 0; first_ov = -1; last_ov = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         check($sformatf("b_cnt%0d", k), 32'(cnt_b), k % 10);
         check($sformatf("b_ov%0d", k), 32'(ov_b), (k % 10 == 0) ? 1 : 0);
         if (ov_b) begin
            ov_cnt++;
            if (first_ov < 0) first_ov = k;
            last_ov = k;
         end
      end
      en_b = 0;
      check("b_ov_pulses", 32'(ov_cnt), 2);
      check("b_ov_spacing", 32'(last_ov - first_ov), 10);

      // WIDTH=2 MAX=0: overflow every enabled edge
      rst_c = 0; en_c = 1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check($sformatf("c_cnt%0d", k), 32'(cnt_c), 0);
         check($sformatf("c_ov%0d", k), 32'(ov_c), 1);
      end
      en_c = 0;
      tick();
      check("c_en_low_ov", 32'(ov_c), 0);
      check("c_en_low_cnt", 32'(cnt_c), 0);
      en_c = 1;
      tick();
      check("c_resume_ov", 32'(ov_c), 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule
